// File: rtl/ymc_pkg.sv
// Shared types and encodings for the ymc multi-cycle control unit.
package ymc_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_R,
    CL_I,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_JAL
  } iclass_t;

  localparam logic [6:0] OPC_R   = 7'h33;
  localparam logic [6:0] OPC_I   = 7'h13;
  localparam logic [6:0] OPC_LW  = 7'h03;
  localparam logic [6:0] OPC_SW  = 7'h23;
  localparam logic [6:0] OPC_BEQ = 7'h63;
  localparam logic [6:0] OPC_JAL = 7'h6F;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;

  localparam logic [1:0] PC_SEQ   = 2'd0;
  localparam logic [1:0] PC_BR    = 2'd1;
  localparam logic [1:0] PC_JMP   = 2'd2;
  localparam logic [1:0] PC_ENTRY = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] TRAP_NONE = 2'd0;
  localparam logic [1:0] TRAP_ILL  = 2'd1;
  localparam logic [1:0] TRAP_BUS  = 2'd2;

endpackage

// File: rtl/ymc_control_decode.sv
// Combinational instruction classifier: opcode/funct3/funct7[5] to class,
// ALU op, ALU operand select and an illegal flag.
module ymc_decode
  import ymc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output iclass_t    cls,
  output logic [2:0] op,
  output logic       alu_src,
  output logic       illegal
);

  // Classify the instruction; anything not explicitly supported is illegal.
  always_comb begin
    cls     = CL_R;
    op      = ALU_ADD;
    alu_src = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_R: begin
        case (funct3)
          3'b000:  op = funct7b5 ? ALU_SUB : ALU_ADD;
          3'b111:  op = ALU_AND;
          3'b110:  op = ALU_OR;
          default: illegal = 1'b1;
        endcase
      end
      OPC_I: begin
        cls     = CL_I;
        alu_src = 1'b1;
        case (funct3)
          3'b000:  op = ALU_ADD;
          3'b111:  op = ALU_AND;
          3'b110:  op = ALU_OR;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LW: begin
        cls     = CL_LW;
        alu_src = 1'b1;
        illegal = (funct3 != 3'b010);
      end
      OPC_SW: begin
        cls     = CL_SW;
        alu_src = 1'b1;
        illegal = (funct3 != 3'b010);
      end
      OPC_BEQ: begin
        cls     = CL_BEQ;
        op      = ALU_SUB;
        illegal = (funct3 != 3'b000);
      end
      OPC_JAL: cls = CL_JAL;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ymc_control.sv
// Multi-cycle control FSM for the RV32 teaching datapath: sequences
// fetch/decode/execute/memory/writeback with memory wait handshaking,
// bus timeout, interrupt entry at instruction boundaries and illegal traps.
module ymc_control
  import ymc_pkg::*;
#(
  parameter logic [31:0] ENTRY = 32'h28,
  parameter int          TO_W  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic        memRdy,
  input  logic        intReq,
  output logic [31:0] entryPoint,
  output logic        pcWrite,
  output logic [1:0]  pcSel,
  output logic        imemRead,
  output logic        irWrite,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  wbSel,
  output logic [2:0]  op,
  output logic        intAck,
  output logic [1:0]  trap,
  output logic [31:0] retired
);

  // Timeout fires on the wait cycle that would bring the counter to all-ones.
  localparam logic [TO_W-1:0] WAIT_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] WAIT_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  state_t          state;
  state_t          next_state;
  iclass_t         dec_cls;
  iclass_t         cls_q;
  logic [2:0]      dec_op;
  logic [2:0]      op_q;
  logic            dec_src;
  logic            src_q;
  logic            dec_ill;
  logic [TO_W-1:0] wait_cnt;
  logic            mem_phase;
  logic            timeout;
  logic            done;
  logic            int_entry;
  logic [1:0]      trap_q;
  logic [31:0]     retired_q;
  logic            unused_ins;

  assign unused_ins = ^{ins[31], ins[29:15], ins[11:7]};

  ymc_decode u_decode (
    .opcode   (ins[6:0]),
    .funct3   (ins[14:12]),
    .funct7b5 (ins[30]),
    .cls      (dec_cls),
    .op       (dec_op),
    .alu_src  (dec_src),
    .illegal  (dec_ill)
  );

  assign mem_phase = (state == ST_FETCH) || (state == ST_MEM);
  assign timeout   = mem_phase && !memRdy && (wait_cnt == WAIT_LAST);

  // Reset exposes nothing to the datapath: constant and counters read 0 too.
  assign entryPoint = rst_n ? ENTRY : 32'd0;
  assign trap       = rst_n ? trap_q : TRAP_NONE;
  assign retired    = rst_n ? retired_q : 32'd0;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_ENTRY;
    else        state <= next_state;
  end

  // Next-state and datapath enables, all forced low while reset is held.
  always_comb begin
    next_state = state;
    done       = 1'b0;
    pcWrite    = 1'b0;
    pcSel      = PC_SEQ;
    imemRead   = 1'b0;
    irWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrc     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    wbSel      = WB_ALU;
    op         = ALU_AND;
    intAck     = 1'b0;
    case (state)
      ST_ENTRY: begin
        pcWrite    = 1'b1;
        pcSel      = PC_ENTRY;
        intAck     = int_entry;
        next_state = ST_FETCH;
      end
      ST_FETCH: begin
        imemRead = 1'b1;
        if (memRdy) begin
          irWrite    = 1'b1;
          next_state = ST_DECODE;
        end else if (timeout) begin
          next_state = ST_HALT;
        end
      end
      ST_DECODE: next_state = dec_ill ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        op     = op_q;
        ALUSrc = src_q;
        case (cls_q)
          CL_BEQ: begin
            // Untaken branches leave PC alone; only live zero commits the target.
            pcSel   = PC_BR;
            pcWrite = zero;
            done    = 1'b1;
          end
          CL_JAL: begin
            pcWrite    = 1'b1;
            pcSel      = PC_JMP;
            next_state = ST_WB;
          end
          CL_LW, CL_SW: next_state = ST_MEM;
          default:      next_state = ST_WB;
        endcase
      end
      ST_MEM: begin
        ALUSrc   = 1'b1;
        op       = ALU_ADD;
        MemRead  = (cls_q == CL_LW);
        MemWrite = (cls_q == CL_SW);
        if (memRdy) begin
          if (cls_q == CL_LW) begin
            next_state = ST_WB;
          end else begin
            pcWrite = 1'b1;
            done    = 1'b1;
          end
        end else if (timeout) begin
          next_state = ST_HALT;
        end
      end
      ST_WB: begin
        RegWrite = 1'b1;
        done     = 1'b1;
        case (cls_q)
          CL_LW: begin
            wbSel   = WB_MEM;
            pcWrite = 1'b1;
          end
          CL_JAL: wbSel = WB_PC4;
          default: begin
            wbSel   = WB_ALU;
            op      = op_q;
            ALUSrc  = src_q;
            pcWrite = 1'b1;
          end
        endcase
      end
      ST_HALT: if (intReq) next_state = ST_ENTRY;
      default: next_state = ST_ENTRY;
    endcase
    if (done) next_state = intReq ? ST_ENTRY : ST_FETCH;
    if (!rst_n) begin
      pcWrite  = 1'b0;
      pcSel    = PC_SEQ;
      imemRead = 1'b0;
      irWrite  = 1'b0;
      RegWrite = 1'b0;
      ALUSrc   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      wbSel    = WB_ALU;
      op       = ALU_AND;
      intAck   = 1'b0;
    end
  end

  // Capture the decode result so EXEC/MEM/WB see a stable classification.
  always_ff @(posedge clk) begin
    if (state == ST_DECODE) begin
      cls_q <= dec_cls;
      op_q  <= dec_op;
      src_q <= dec_src;
    end
  end

  // Wait counter, trap status, interrupt-entry flag and retirement count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      trap_q    <= TRAP_NONE;
      int_entry <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      if (next_state != state)        wait_cnt <= '0;
      else if (mem_phase && !memRdy)  wait_cnt <= wait_cnt + WAIT_ONE;
      if (state == ST_DECODE && dec_ill) trap_q <= TRAP_ILL;
      else if (timeout)                  trap_q <= TRAP_BUS;
      else if (next_state == ST_ENTRY)   trap_q <= TRAP_NONE;
      int_entry <= (next_state == ST_ENTRY);
      if (done) retired_q <= retired_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_ymc_control.sv
// Scoreboard bench for ymc_control: the driver walks directed instruction
// sequences and queues hand-computed per-cycle expectations; a monitor on
// the falling edge pops and compares them against the DUT outputs.
module tb_ymc_control;

  localparam logic [31:0] EP     = 32'h28;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h00012083;
  localparam logic [31:0] I_SW   = 32'h00112023;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ins = 32'd0;
  logic        zero = 1'b0;
  logic        memRdy = 1'b0;
  logic        intReq = 1'b0;
  logic [31:0] entryPoint;
  logic        pcWrite;
  logic [1:0]  pcSel;
  logic        imemRead;
  logic        irWrite;
  logic        RegWrite;
  logic        ALUSrc;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  wbSel;
  logic [2:0]  op;
  logic        intAck;
  logic [1:0]  trap;
  logic [31:0] retired;

  ymc_control #(.ENTRY(32'h28), .TO_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ins        (ins),
    .zero       (zero),
    .memRdy     (memRdy),
    .intReq     (intReq),
    .entryPoint (entryPoint),
    .pcWrite    (pcWrite),
    .pcSel      (pcSel),
    .imemRead   (imemRead),
    .irWrite    (irWrite),
    .RegWrite   (RegWrite),
    .ALUSrc     (ALUSrc),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .wbSel      (wbSel),
    .op         (op),
    .intAck     (intAck),
    .trap       (trap),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [16:0] v;
    logic [31:0] ep;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   checks = 0;
  int   errors = 0;

  logic [16:0] act;
  assign act = {pcWrite, pcSel, imemRead, irWrite, RegWrite, ALUSrc,
                MemRead, MemWrite, wbSel, op, intAck, trap};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Vector order: pcWrite pcSel imemRead irWrite RegWrite ALUSrc MemRead MemWrite wbSel op intAck trap
  task automatic ex(input string nm, input int pw, input int ps, input int im, input int iw,
                    input int rw, input int as, input int mr, input int mw, input int wb,
                    input int o, input int ack, input int tr, input logic [31:0] ep, input int ret);
    exp_t e;
    e.cyc  = cyc;
    e.name = nm;
    e.v    = {1'(pw), 2'(ps), 1'(im), 1'(iw), 1'(rw), 1'(as), 1'(mr), 1'(mw),
              2'(wb), 3'(o), 1'(ack), 2'(tr)};
    e.ep   = ep;
    e.ret  = 32'(ret);
    sb.push_back(e);
  endtask

  task automatic ex_entry(input string nm, input int ack, input int ret);
    ex(nm, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, ack, 0, EP, ret);
  endtask

  task automatic ex_fetch(input string nm, input int rdy, input int tr, input int ret);
    ex(nm, 0, 0, 1, rdy, 0, 0, 0, 0, 0, 0, 0, tr, EP, ret);
  endtask

  task automatic ex_idle(input string nm, input int tr, input int ret);
    ex(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tr, EP, ret);
  endtask

  task automatic ex_gated(input string nm);
    ex(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0);
  endtask

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      m = sb.pop_front();
      checks++;
      if (act !== m.v || entryPoint !== m.ep || retired !== m.ret) begin
        errors++;
        $display("FAIL %s: got ctl=%05h ep=%08h ret=%0d, want ctl=%05h ep=%08h ret=%0d",
                 m.name, act, entryPoint, retired, m.v, m.ep, m.ret);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then add with zero-wait memory.
    rst_n = 1'b0;
    step(); ex_gated("reset_low");
    step(); rst_n = 1'b1; ins = I_ADD; memRdy = 1'b1; ex_entry("add_entry", 0, 0);
    step(); ex_fetch("add_fetch", 1, 0, 0);
    step(); ex_idle("add_decode", 0, 0);
    step(); ex("add_exec", 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, EP, 0);
    step(); ex("add_wb", 1, 0, 0, 0, 1, 0, 0, 0, 0, 3'b010, 0, 0, EP, 0);

    // lw with three data-memory wait cycles.
    step(); ins = I_LW; ex_fetch("lw_fetch", 1, 0, 1);
    step(); ex_idle("lw_decode", 0, 1);
    step(); memRdy = 1'b0; ex("lw_exec", 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b010, 0, 0, EP, 1);
    for (int i = 0; i < 3; i++) begin
      step(); ex("lw_mem_wait", 0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b010, 0, 0, EP, 1);
    end
    step(); memRdy = 1'b1; ex("lw_mem_rdy", 0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b010, 0, 0, EP, 1);
    step(); ex("lw_wb", 1, 0, 0, 0, 1, 0, 0, 0, 1, 3'b000, 0, 0, EP, 1);

    // beq taken, then not taken.
    step(); ins = I_BEQ; zero = 1'b1; ex_fetch("beq1_fetch", 1, 0, 2);
    step(); ex_idle("beq1_decode", 0, 2);
    step(); ex("beq_exec_taken", 1, 1, 0, 0, 0, 0, 0, 0, 0, 3'b110, 0, 0, EP, 2);
    step(); zero = 1'b0; ex_fetch("beq2_fetch", 1, 0, 3);
    step(); ex_idle("beq2_decode", 0, 3);
    step(); ex("beq_exec_untaken", 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b110, 0, 0, EP, 3);

    // sw with interrupt raised during MEM: completes, then interrupt entry.
    step(); ins = I_SW; ex_fetch("sw_fetch", 1, 0, 4);
    step(); ex_idle("sw_decode", 0, 4);
    step(); ex("sw_exec", 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b010, 0, 0, EP, 4);
    step(); memRdy = 1'b0; intReq = 1'b1;
    ex("sw_mem_wait", 0, 0, 0, 0, 0, 1, 0, 1, 0, 3'b010, 0, 0, EP, 4);
    step(); memRdy = 1'b1; ex("sw_mem_rdy", 1, 0, 0, 0, 0, 1, 0, 1, 0, 3'b010, 0, 0, EP, 4);
    step(); intReq = 1'b0; ex_entry("sw_int_entry", 1, 5);

    // Illegal instruction traps to HALT; interrupt leaves HALT and clears trap.
    step(); ins = I_BAD; ex_fetch("ill_fetch_noack", 1, 0, 5);
    step(); ex_idle("ill_decode", 0, 5);
    step(); ex_idle("ill_halt", 1, 5);
    step(); intReq = 1'b1; ex_idle("ill_halt_int", 1, 5);
    step(); intReq = 1'b0; memRdy = 1'b0; ex_entry("ill_exit_entry", 1, 5);

    // Instruction fetch never completes: 15 wait cycles, then bus trap.
    for (int i = 0; i < 15; i++) begin
      step(); ex_fetch("to_fetch_wait", 0, 0, 5);
    end
    step(); ex_idle("to_halt", 2, 5);
    step(); intReq = 1'b1; ex_idle("to_halt_int", 2, 5);
    step(); intReq = 1'b0; memRdy = 1'b1; ins = I_SW; ex_entry("to_exit_entry", 1, 5);

    // Reset asserted during a sw memory wait drops MemWrite immediately.
    step(); ex_fetch("rst_sw_fetch", 1, 0, 5);
    step(); ex_idle("rst_sw_decode", 0, 5);
    step(); memRdy = 1'b0; ex("rst_sw_exec", 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b010, 0, 0, EP, 5);
    step(); ex("rst_sw_mem", 0, 0, 0, 0, 0, 1, 0, 1, 0, 3'b010, 0, 0, EP, 5);
    step(); rst_n = 1'b0; ex_gated("rst_mid_mem");
    step(); ex_gated("rst_hold");
    step(); rst_n = 1'b1; memRdy = 1'b1; ins = I_ADD; ex_entry("rst_exit_entry", 0, 0);
    step(); ex_fetch("rst_exit_fetch", 1, 0, 0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
